// File: rtl/bayer2rgb_frame_ctrl.sv
// AHB-lite frame sequencer for the Bayer2RGB datapath: gates the datapath enable
// on frame boundaries, counts lines/frames, flags framing errors, raises a done IRQ.
module bayer2rgb_frame_ctrl #(
    parameter int FRAME_LINES = 480,
    parameter int FCNT_W      = 16
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic [3:0]  HPROT,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic        HRESP,
    input  logic        frame_start,
    input  logic        line_end,
    output logic        bayer_en,
    output logic        irq
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARM    = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    localparam logic [11:0] FRAME_LINES_C = 12'(FRAME_LINES);

    state_t              state_r, state_nx;
    logic                addr_valid_r, write_r;
    logic [1:0]          addr_r;
    logic                en_r, single_r, irq_en_r, done_r, err_r;
    logic                en_nx, single_nx, irq_en_nx, done_nx, err_nx;
    logic [11:0]         line_r, line_nx;
    logic [FCNT_W-1:0]   fcnt_r, fcnt_nx;
    logic                bayer_en_r, irq_r;
    logic                done_set_s, err_set_s, single_clr_s;
    logic                wr_ctrl_s, wr_status_s, abort_s, addr_sel_s;
    logic [31:0]         hrdata_s;
    logic                unused_s;

    assign addr_sel_s  = HSEL & HTRANS[1] & HREADY;
    assign wr_ctrl_s   = addr_valid_r & write_r & (addr_r == 2'd0);
    assign wr_status_s = addr_valid_r & write_r & (addr_r == 2'd1);
    assign abort_s     = wr_ctrl_s & HWDATA[3];
    assign unused_s    = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HSIZE, HPROT, HWDATA[31:4]};

    // AHB address-phase capture; idle or unselected cycles drop the pending access
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_valid_r <= 1'b0;
            addr_r       <= 2'd0;
            write_r      <= 1'b0;
        end else if (HREADY) begin
            addr_valid_r <= addr_sel_s;
            if (addr_sel_s) begin
                addr_r  <= HADDR[3:2];
                write_r <= HWRITE;
            end
        end
    end

    // Sequencer next state, line/frame counting and hardware status events
    always_comb begin
        state_nx     = state_r;
        line_nx      = line_r;
        fcnt_nx      = fcnt_r;
        done_set_s   = 1'b0;
        err_set_s    = 1'b0;
        single_clr_s = 1'b0;
        if (abort_s) begin
            state_nx = ST_IDLE;
            line_nx  = 12'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (en_r) state_nx = ST_ARM;
                    else      state_nx = ST_IDLE;
                end
                ST_ARM: begin
                    if (!en_r) begin
                        state_nx = ST_IDLE;
                    end else if (frame_start) begin
                        state_nx = ST_ACTIVE;
                        line_nx  = 12'd0;
                    end else begin
                        state_nx = ST_ARM;
                    end
                end
                ST_ACTIVE: begin
                    // A frame_start mid-frame restarts the line count; line_end that cycle is dropped
                    if (frame_start) begin
                        err_set_s = 1'b1;
                        line_nx   = 12'd0;
                    end else if (line_end) begin
                        if ((line_r + 12'd1) == FRAME_LINES_C) begin
                            fcnt_nx    = fcnt_r + FCNT_W'(1);
                            done_set_s = 1'b1;
                            line_nx    = 12'd0;
                            if (single_r) begin
                                single_clr_s = 1'b1;
                                state_nx     = ST_IDLE;
                            end else if (!en_r) begin
                                state_nx = ST_IDLE;
                            end else begin
                                state_nx = ST_ARM;
                            end
                        end else begin
                            line_nx = line_r + 12'd1;
                        end
                    end else begin
                        state_nx = ST_ACTIVE;
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    // Software-visible control and sticky status; software EN write beats the SINGLE clear
    always_comb begin
        if (abort_s)           en_nx = 1'b0;
        else if (wr_ctrl_s)    en_nx = HWDATA[0];
        else if (single_clr_s) en_nx = 1'b0;
        else                   en_nx = en_r;
        if (wr_ctrl_s) begin
            single_nx = HWDATA[1];
            irq_en_nx = HWDATA[2];
        end else begin
            single_nx = single_r;
            irq_en_nx = irq_en_r;
        end
        done_nx = done_set_s | (done_r & ~(wr_status_s & HWDATA[1]));
        err_nx  = err_set_s  | (err_r  & ~(wr_status_s & HWDATA[2]));
    end

    // State, counters, control/status registers and registered outputs
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_r    <= ST_IDLE;
            line_r     <= 12'd0;
            fcnt_r     <= '0;
            en_r       <= 1'b0;
            single_r   <= 1'b0;
            irq_en_r   <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            bayer_en_r <= 1'b0;
            irq_r      <= 1'b0;
        end else begin
            state_r    <= state_nx;
            line_r     <= line_nx;
            fcnt_r     <= fcnt_nx;
            en_r       <= en_nx;
            single_r   <= single_nx;
            irq_en_r   <= irq_en_nx;
            done_r     <= done_nx;
            err_r      <= err_nx;
            bayer_en_r <= (state_nx == ST_ACTIVE);
            irq_r      <= irq_en_r & done_r;
        end
    end

    // Read mux driven by the latched data-phase address
    always_comb begin
        case (addr_r)
            2'd0:    hrdata_s = {29'd0, irq_en_r, single_r, en_r};
            2'd1:    hrdata_s = {27'd0, state_r, err_r, done_r, (state_r != ST_IDLE)};
            2'd2:    hrdata_s = 32'(fcnt_r);
            2'd3:    hrdata_s = {20'd0, line_r};
            default: hrdata_s = 32'd0;
        endcase
    end

    assign HRDATA    = hrdata_s;
    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign bayer_en  = bayer_en_r;
    assign irq       = irq_r;

endmodule
